// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the fft_sched frame scheduler:
//   - state_t       : scheduler FSM states (IDLE, LOAD, WAIT)
//   - DEF_N, DEF_DW : default FFT frame length and sample component width
//   - cnt_width()   : width of a counter that must hold the value N
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_N  = 64;
  localparam int DEF_DW = 16;

  // One extra bit over log2(n) so the counter can represent n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fft_rr_arb.sv
// -----------------------------------------------------------------------------
// fft_rr_arb
// Combinational round-robin priority picker. Scans req starting at rr_ptr and
// moving upward with wrap-around; the first set bit wins.
// Ports:
//   req        in  NCH  request vector
//   rr_ptr     in  CW   highest-priority index for this pick
//   gnt_onehot out NCH  one-hot winner (all zero when no request)
//   gnt_idx    out CW   binary index of the winner (0 when no request)
//   gnt_any    out 1    at least one request present
// -----------------------------------------------------------------------------
module fft_rr_arb
  import fft_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  rr_ptr,
  output logic [NCH-1:0] gnt_onehot,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  // One extra bit so rr_ptr + offset can be wrapped without overflow.
  localparam int SW = CW + 1;

  logic [SW-1:0] cand_s;

  // Priority scan from rr_ptr upward; earlier candidates in the scan win.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand_s     = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_s = {1'b0, rr_ptr} + SW'(i);
      cand_s = (cand_s >= SW'(NCH)) ? (cand_s - SW'(NCH)) : cand_s;
      if (!gnt_any && req[cand_s[CW-1:0]]) begin
        gnt_any                     = 1'b1;
        gnt_idx                     = cand_s[CW-1:0];
        gnt_onehot[cand_s[CW-1:0]]  = 1'b1;
      end else begin
        // an earlier candidate in the scan already holds the grant
      end
    end
  end

endmodule

// File: rtl/fft_sched.sv
// -----------------------------------------------------------------------------
// fft_sched
// Frame-level round-robin scheduler sharing one streaming FFT engine between
// NCH channels. A granted channel supplies exactly N samples (gaps allowed),
// then the N engine results are returned tagged with the owning channel.
//
// Optional build macro FFT_SCHED_STATS_EN adds stat_frames: one 16-bit
// wrapping frame counter per channel (cleared by rst_n only, not by flush).
//
// Ports:
//   clk, rst_n (sync, active low), flush (abort frame, pulse engine reset)
//   ch_valid/ch_ready/ch_real/ch_imag : per-channel sample inputs (packed)
//   fft_rst, fft_in_valid/real/imag    : engine reset and sample stream
//   fft_out_valid/real/imag            : engine result stream
//   res_valid/real/imag/chan/last      : tagged result stream
//   busy                               : scheduler not idle
//   stat_frames (macro only)           : per-channel completed frame counts
// -----------------------------------------------------------------------------
module fft_sched
  import fft_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int N   = DEF_N,
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_real,
  input  logic [NCH*DW-1:0] ch_imag,
  output logic              fft_rst,
  output logic              fft_in_valid,
  output logic [DW-1:0]     fft_in_real,
  output logic [DW-1:0]     fft_in_imag,
  input  logic              fft_out_valid,
  input  logic [DW-1:0]     fft_out_real,
  input  logic [DW-1:0]     fft_out_imag,
  output logic              res_valid,
  output logic [DW-1:0]     res_real,
  output logic [DW-1:0]     res_imag,
  output logic [CW-1:0]     res_chan,
  output logic              res_last,
  output logic              busy
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [NCH*16-1:0] stat_frames
`endif
);

  localparam int KW = cnt_width(N);

  state_t          state_r;
  logic [CW-1:0]   gnt_r;
  logic [CW-1:0]   rr_ptr_r;
  logic [KW-1:0]   scnt_r;
  logic [KW-1:0]   rcnt_r;

  logic [NCH-1:0]  arb_onehot_s;
  logic [CW-1:0]   arb_idx_s;
  logic            arb_any_s;
  logic            xfer_s;
  logic            sample_last_s;
  logic            beat_last_s;
  logic [CW-1:0]   rr_next_s;

  fft_rr_arb #(.NCH(NCH)) u_arb (
    .req        (ch_valid),
    .rr_ptr     (rr_ptr_r),
    .gnt_onehot (arb_onehot_s),
    .gnt_idx    (arb_idx_s),
    .gnt_any    (arb_any_s)
  );

  assign xfer_s        = (state_r == LOAD) & ch_valid[gnt_r] & ch_ready[gnt_r];
  assign sample_last_s = (scnt_r == KW'(N - 1));
  assign beat_last_s   = (rcnt_r == KW'(N - 1));
  assign rr_next_s     = (gnt_r == CW'(NCH - 1)) ? '0 : (gnt_r + CW'(1));

  // Scheduler FSM with registered handshake, engine and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      rr_ptr_r     <= '0;
      scnt_r       <= '0;
      rcnt_r       <= '0;
      ch_ready     <= '0;
      fft_rst      <= 1'b1;
      fft_in_valid <= 1'b0;
      fft_in_real  <= '0;
      fft_in_imag  <= '0;
      res_valid    <= 1'b0;
      res_real     <= '0;
      res_imag     <= '0;
      res_chan     <= '0;
      res_last     <= 1'b0;
      busy         <= 1'b0;
    end else if (flush) begin
      // Abort: partial frame dropped, engine reset for one cycle, rr_ptr kept.
      state_r      <= IDLE;
      gnt_r        <= '0;
      scnt_r       <= '0;
      rcnt_r       <= '0;
      ch_ready     <= '0;
      fft_rst      <= 1'b1;
      fft_in_valid <= 1'b0;
      fft_in_real  <= '0;
      fft_in_imag  <= '0;
      res_valid    <= 1'b0;
      res_real     <= '0;
      res_imag     <= '0;
      res_chan     <= '0;
      res_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fft_rst      <= 1'b0;
      fft_in_valid <= 1'b0;
      res_valid    <= 1'b0;
      res_last     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            gnt_r    <= arb_idx_s;
            ch_ready <= arb_onehot_s;
            scnt_r   <= '0;
            state_r  <= LOAD;
            busy     <= 1'b1;
          end else begin
            ch_ready <= '0;
            busy     <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            fft_in_valid <= 1'b1;
            fft_in_real  <= ch_real[gnt_r*DW +: DW];
            fft_in_imag  <= ch_imag[gnt_r*DW +: DW];
            scnt_r       <= scnt_r + KW'(1);
            if (sample_last_s) begin
              ch_ready <= '0;
              rcnt_r   <= '0;
              state_r  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fft_out_valid) begin
            res_valid <= 1'b1;
            res_real  <= fft_out_real;
            res_imag  <= fft_out_imag;
            res_chan  <= gnt_r;
            rcnt_r    <= rcnt_r + KW'(1);
            if (beat_last_s) begin
              res_last <= 1'b1;
              rr_ptr_r <= rr_next_s;
              state_r  <= IDLE;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          ch_ready <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] stat_r [NCH];

  // Per-channel completed-frame counters; survive flush, cleared by rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        stat_r[c] <= 16'd0;
      end
    end else if (!flush && (state_r == WAIT) && fft_out_valid && beat_last_s) begin
      stat_r[gnt_r] <= stat_r[gnt_r] + 16'd1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign stat_frames[g*16 +: 16] = stat_r[g];
  end
`endif

endmodule

// File: tb/tb_fft_sched.sv
module tb_fft_sched;

  localparam int DW  = 16;
  localparam int N   = 64;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NCH-1:0]    ch_valid = '0;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_real = '0;
  logic [NCH*DW-1:0] ch_imag = '0;
  logic              fft_rst;
  logic              fft_in_valid;
  logic [DW-1:0]     fft_in_real;
  logic [DW-1:0]     fft_in_imag;
  logic              fft_out_valid = 1'b0;
  logic [DW-1:0]     fft_out_real = '0;
  logic [DW-1:0]     fft_out_imag = '0;
  logic              res_valid;
  logic [DW-1:0]     res_real;
  logic [DW-1:0]     res_imag;
  logic [CW-1:0]     res_chan;
  logic              res_last;
  logic              busy;
`ifdef FFT_SCHED_STATS_EN
  logic [NCH*16-1:0] stat_frames;
`endif

  fft_sched #(.DW(DW), .N(N), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_real(ch_real), .ch_imag(ch_imag),
    .fft_rst(fft_rst), .fft_in_valid(fft_in_valid),
    .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_out_valid(fft_out_valid), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .res_valid(res_valid), .res_real(res_real), .res_imag(res_imag),
    .res_chan(res_chan), .res_last(res_last), .busy(busy)
`ifdef FFT_SCHED_STATS_EN
    , .stat_frames(stat_frames)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int chan; logic [DW-1:0] re; logic [DW-1:0] im; } sent_t;
  typedef struct { logic [CW-1:0] chan; logic last; logic [2*DW-1:0] data; } res_t;

  sent_t           src_sent_q[$];   // samples the sources handed over
  logic [2*DW-1:0] obs_in_q[$];     // samples seen on the engine input
  res_t            obs_res_q[$];    // tagged results seen
  logic [2*DW-1:0] drv_res_q[$];    // results the engine model produced
  logic [2*DW-1:0] eng_q[$];

  int   src_budget[NCH];
  int   src_pos[NCH];
  logic [DW-1:0] cur_im[NCH];
  bit   pend[NCH];
  int   rdy_cnt[NCH];
  bit   src_stall = 1'b0;
  bit   spur_en = 1'b0;
  bit   emitting = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr = 0;

  // Sources, engine model and output logging, all at the falling edge.
  initial begin
    bit v;
    logic [2*DW-1:0] x, o;
    res_t r;
    for (int c = 0; c < NCH; c++) begin
      src_budget[c] = 0; src_pos[c] = 0; cur_im[c] = 16'($urandom); pend[c] = 1'b0; rdy_cnt[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (fft_in_valid) obs_in_q.push_back({fft_in_real, fft_in_imag});
      if (res_valid) begin
        r.chan = res_chan; r.last = res_last; r.data = {res_real, res_imag};
        obs_res_q.push_back(r);
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_ready[c]) rdy_cnt[c]++;
        if (pend[c]) begin
          src_pos[c]++; cur_im[c] = 16'($urandom); src_budget[c]--;
        end
        v = (src_budget[c] > 0) && (!src_stall || ($urandom_range(0, 1) == 1));
        ch_valid[c] = v;
        ch_real[c*DW +: DW] = DW'(src_pos[c]);
        ch_imag[c*DW +: DW] = cur_im[c];
      end
      fft_out_valid = 1'b0;
      if (fft_rst) begin
        eng_q.delete(); emitting = 1'b0;
      end else begin
        if (fft_in_valid) eng_q.push_back({fft_in_real, fft_in_imag});
        if (!emitting && eng_q.size() == N) emitting = 1'b1;
        if (emitting) begin
          if ($urandom_range(0, 3) != 0) begin
            x = eng_q.pop_front();
            o = {x[2*DW-1:DW] ^ 16'h5A5A, x[DW-1:0] + 16'd3};
            fft_out_valid = 1'b1; fft_out_real = o[2*DW-1:DW]; fft_out_imag = o[DW-1:0];
            drv_res_q.push_back(o);
            if (eng_q.size() == 0) emitting = 1'b0;
          end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
          fft_out_valid = 1'b1; fft_out_real = 16'($urandom); fft_out_imag = 16'($urandom);
        end
      end
      #1;
      for (int c = 0; c < NCH; c++) begin
        pend[c] = ch_valid[c] && ch_ready[c] && !flush && rst_n;
        if (pend[c]) src_sent_q.push_back('{c, DW'(src_pos[c]), cur_im[c]});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    src_sent_q.delete(); obs_in_q.delete(); obs_res_q.delete(); drv_res_q.delete();
    for (int c = 0; c < NCH; c++) rdy_cnt[c] = 0;
  endtask

  // Reference arbitration: first requester at or after m_ptr, wrapping.
  function automatic int exp_grant(input logic [NCH-1:0] req);
    for (int k = 0; k < NCH; k++) begin
      if (req[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  // Waits for one complete frame and compares it against the reference.
  task automatic verify_frame(input int exp_ch);
    int waited, n;
    waited = 0;
    while (obs_res_q.size() < N && waited < 40 * N) begin step(); waited++; end
    n_checks++;
    if (obs_res_q.size() != N) begin
      n_errors++; $display("FAIL frame_res_count ch%0d: got %0d beats, want %0d", exp_ch, obs_res_q.size(), N);
    end
    n_checks++;
    if (obs_in_q.size() != N || src_sent_q.size() != N) begin
      n_errors++; $display("FAIL frame_in_count ch%0d: in=%0d sent=%0d, want %0d", exp_ch, obs_in_q.size(), src_sent_q.size(), N);
    end
    n = (src_sent_q.size() < obs_in_q.size()) ? src_sent_q.size() : obs_in_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (src_sent_q[i].chan != exp_ch) begin
        n_errors++; $display("FAIL grant beat%0d: channel %0d transferred, want %0d", i, src_sent_q[i].chan, exp_ch);
      end
      n_checks++;
      if (obs_in_q[i] !== {src_sent_q[i].re, src_sent_q[i].im}) begin
        n_errors++; $display("FAIL in_data beat%0d: got %h want %h", i, obs_in_q[i], {src_sent_q[i].re, src_sent_q[i].im});
      end
    end
    n = (obs_res_q.size() < drv_res_q.size()) ? obs_res_q.size() : drv_res_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_res_q[i].chan !== CW'(exp_ch) || obs_res_q[i].last !== (i == N - 1) || obs_res_q[i].data !== drv_res_q[i]) begin
        n_errors++;
        $display("FAIL res beat%0d: chan=%0d last=%0b data=%h, want chan=%0d last=%0b data=%h",
                 i, obs_res_q[i].chan, obs_res_q[i].last, obs_res_q[i].data, exp_ch, (i == N - 1), drv_res_q[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_after_frame: got %b want 0", busy); end
    m_ptr = (exp_ch + 1) % NCH;
  endtask

  task automatic check_quiet(input string tag, input logic exp_rst);
    logic [NCH+4*DW+CW+4-1:0] outs;
    outs = {ch_ready, fft_in_valid, fft_in_real, fft_in_imag, res_valid, res_real, res_imag, res_chan, res_last, busy};
    n_checks++;
    if (outs !== '0 || fft_rst !== exp_rst) begin
      n_errors++; $display("FAIL %s: outputs=%h fft_rst=%b, want 0 and fft_rst=%b", tag, outs, fft_rst, exp_rst);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); check_quiet("reset_state", 1'b1); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (fft_rst !== 1'b1) begin n_errors++; $display("FAIL reset_release_hold: fft_rst=%b want 1", fft_rst); end
    step();
    check_quiet("reset_released", 1'b0);
    m_ptr = 0;
    clear_logs();
  endtask

  task automatic test_single_channel();
    int e;
    clear_logs();
    src_budget[2] = N;
    e = exp_grant(4'b0100);
    verify_frame(e);
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (rdy_cnt[c] != ((c == 2) ? N : 0)) begin
        n_errors++; $display("FAIL ready_cycles ch%0d: got %0d want %0d", c, rdy_cnt[c], (c == 2) ? N : 0);
      end
    end
    clear_logs();
  endtask

  task automatic test_round_robin();
    int frames_left[NCH];
    logic [NCH-1:0] req;
    int e;
    clear_logs();
    frames_left = '{2, 1, 1, 1};
    for (int c = 0; c < NCH; c++) src_budget[c] = frames_left[c] * N;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < NCH; c++) req[c] = (frames_left[c] > 0);
      e = exp_grant(req);
      verify_frame(e);
      clear_logs();
      frames_left[e]--;
    end
  endtask

  task automatic test_stall();
    int start, e;
    clear_logs();
    src_stall = 1'b1; spur_en = 1'b1;
    start = src_pos[3];
    src_budget[3] = N;
    e = exp_grant(4'b1000);
    verify_frame(e);
    for (int i = 0; i < obs_in_q.size(); i++) begin
      n_checks++;
      if (obs_in_q[i][2*DW-1:DW] !== DW'(start + i)) begin
        n_errors++; $display("FAIL stall_seq beat%0d: got %0d want %0d", i, obs_in_q[i][2*DW-1:DW], start + i);
      end
    end
    clear_logs();
    src_stall = 1'b0; spur_en = 1'b0;
  endtask

  task automatic test_flush();
    int waited, e;
    clear_logs();
    src_budget[0] = N; src_budget[2] = N;
    waited = 0;
    while (src_sent_q.size() < 20 && waited < 1000) begin step(); waited++; end
    n_checks++;
    if (src_sent_q.size() < 20) begin n_errors++; $display("FAIL flush_setup: %0d samples sent, want 20", src_sent_q.size()); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_quiet("flush_state", 1'b1);
    n_checks++;
    if (obs_res_q.size() != 0) begin n_errors++; $display("FAIL flush_no_res: %0d results, want 0", obs_res_q.size()); end
    clear_logs();
    src_budget[0] = N;
    step();
    n_checks++;
    if (fft_rst !== 1'b0) begin n_errors++; $display("FAIL flush_pulse_len: fft_rst=%b want 0", fft_rst); end
    e = exp_grant(4'b0101);
    verify_frame(e);
    clear_logs();
    e = exp_grant(4'b0100);
    verify_frame(e);
    clear_logs();
  endtask

  task automatic test_reset_mid_wait();
    int waited, e;
    clear_logs();
    src_budget[2] = N;
    waited = 0;
    while (obs_res_q.size() < 5 && waited < 2000) begin step(); waited++; end
    n_checks++;
    if (obs_res_q.size() < 5) begin n_errors++; $display("FAIL wait_setup: %0d results, want 5", obs_res_q.size()); end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); check_quiet("midwait_reset", 1'b1); end
    clear_logs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (fft_rst !== 1'b1) begin n_errors++; $display("FAIL midwait_release: fft_rst=%b want 1", fft_rst); end
    step();
    check_quiet("midwait_released", 1'b0);
    m_ptr = 0;
    src_budget[1] = N; src_budget[3] = N;
    e = exp_grant(4'b1010);
    verify_frame(e);
    clear_logs();
    e = exp_grant(4'b1000);
    verify_frame(e);
    clear_logs();
  endtask

`ifdef FFT_SCHED_STATS_EN
  task automatic test_stats();
    int e;
    clear_logs();
    src_budget[1] = 2 * N;
    for (int f = 0; f < 2; f++) begin
      e = exp_grant(4'b0010);
      verify_frame(e);
      clear_logs();
    end
    n_checks++;
    if (stat_frames !== {16'd1, 16'd0, 16'd3, 16'd0}) begin
      n_errors++; $display("FAIL stat_frames: got %h want %h", stat_frames, {16'd1, 16'd0, 16'd3, 16'd0});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_flush();
    test_reset_mid_wait();
`ifdef FFT_SCHED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
